// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_write_arbiter_pkg
// Shared definitions for the register-file write arbiter: default widths,
// controller state encoding and requester index constants.
package regfile_write_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_SEL_WIDTH  = 2;

  // Controller states: normal arbitration, or sequencing a clear-all.
  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Bit positions of each requester in the grant/valid vectors.
  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if
// Bundles the requester handshakes, the clear control, the read-select
// mirrors, the hazard flags and the register-file write port.
//   slave  : the arbiter (consumes requests, drives the write port)
//   master : the environment (requesters, clear source, register file side)
//
// Handshake: a requester's write is accepted in the cycle where its valid
// and ready are both high. ready is combinational; sel/data must be held
// stable while valid is high and ready is low, and valid must not drop
// until the write has been accepted.
interface regfile_write_arbiter_if
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SEL_WIDTH  = DEF_SEL_WIDTH
) ();

  logic                  req0_valid;
  logic [SEL_WIDTH-1:0]  req0_sel;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;

  logic                  req1_valid;
  logic [SEL_WIDTH-1:0]  req1_sel;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;

  logic                  clear_start;
  logic                  clear_busy;

  logic [SEL_WIDTH-1:0]  read_port0_select;
  logic [SEL_WIDTH-1:0]  read_port1_select;
  logic                  hazard0;
  logic                  hazard1;

  logic                  write_enable;
  logic [SEL_WIDTH-1:0]  write_select;
  logic [DATA_WIDTH-1:0] reg_input;
  logic                  last_grant;

  modport slave (
    input  req0_valid, req0_sel, req0_data,
    output req0_ready,
    input  req1_valid, req1_sel, req1_data,
    output req1_ready,
    input  clear_start,
    output clear_busy,
    input  read_port0_select, read_port1_select,
    output hazard0, hazard1,
    output write_enable, write_select, reg_input, last_grant
  );

  modport master (
    output req0_valid, req0_sel, req0_data,
    input  req0_ready,
    output req1_valid, req1_sel, req1_data,
    input  req1_ready,
    output clear_start,
    input  clear_busy,
    output read_port0_select, read_port1_select,
    input  hazard0, hazard1,
    input  write_enable, write_select, reg_input, last_grant
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// rr_arbiter2
// Two-way round-robin grant with a last-grant flop.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   en       : grants may be issued this cycle
//   valid    : request vector, bit 0 = requester 0
//   grant    : one-hot (or zero) grant vector, combinational
//   last     : requester that won the most recent grant (resets to 1 so
//              requester 0 wins the first contention)
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       last
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      // On contention the requester that did not win last time goes first.
      if (&valid) grant = last ? 2'b01 : 2'b10;
      else        grant = valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last <= 1'b1;
    else if (|grant) last <= grant[1];
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single write port of the register file between the ALU
// writeback (requester 0) and the load writeback (requester 1), sequences
// a clear-all operation through the same port, and flags read-after-write
// hazards on both read ports.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : slave side of regfile_write_arbiter_if (handshakes, clear,
//               read-select mirrors, hazards, registered write port)
//   dbg_state : current controller state
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int                    SEL_WIDTH   = DEF_SEL_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_write_arbiter_if.slave bus,
  output state_e                dbg_state
);

  state_e                state, state_next;
  logic [SEL_WIDTH-1:0]  clear_idx, clear_idx_next;

  logic                  we_q, we_next;
  logic [SEL_WIDTH-1:0]  ws_q, ws_next;
  logic [DATA_WIDTH-1:0] ri_q, ri_next;
  logic                  busy_q, busy_next;

  logic [1:0]            valid;
  logic [1:0]            grant;
  logic                  arb_en;
  logic                  last;

  assign valid  = {bus.req1_valid, bus.req0_valid};
  // A clear request pre-empts arbitration in the cycle it arrives.
  assign arb_en = (state == ARB) && !bus.clear_start;

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .valid (valid),
    .grant (grant),
    .last  (last)
  );

  // Next state plus the values the registered write port loads at the edge.
  always_comb begin
    state_next     = state;
    clear_idx_next = clear_idx;
    we_next        = 1'b0;
    ws_next        = ws_q;
    ri_next        = ri_q;
    busy_next      = 1'b0;
    case (state)
      ARB: begin
        if (bus.clear_start) begin
          // Index 0 goes out on the port immediately; the CLEAR state
          // issues the remaining indices.
          state_next     = CLEAR;
          clear_idx_next = SEL_WIDTH'(1);
          we_next        = 1'b1;
          ws_next        = '0;
          ri_next        = CLEAR_VALUE;
          busy_next      = 1'b1;
        end else if (grant[REQ_ALU]) begin
          we_next = 1'b1;
          ws_next = bus.req0_sel;
          ri_next = bus.req0_data;
        end else if (grant[REQ_LOAD]) begin
          we_next = 1'b1;
          ws_next = bus.req1_sel;
          ri_next = bus.req1_data;
        end
      end
      CLEAR: begin
        we_next        = 1'b1;
        ws_next        = clear_idx;
        ri_next        = CLEAR_VALUE;
        busy_next      = 1'b1;
        // Wraps back to 0 after the last register is issued.
        clear_idx_next = clear_idx + SEL_WIDTH'(1);
        if (&clear_idx) state_next = ARB;
      end
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB;
      clear_idx <= '0;
      we_q      <= 1'b0;
      ws_q      <= '0;
      ri_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_next;
      clear_idx <= clear_idx_next;
      we_q      <= we_next;
      ws_q      <= ws_next;
      ri_q      <= ri_next;
      busy_q    <= busy_next;
    end
  end

  assign bus.req0_ready   = grant[REQ_ALU];
  assign bus.req1_ready   = grant[REQ_LOAD];
  assign bus.clear_busy   = busy_q;
  assign bus.write_enable = we_q;
  assign bus.write_select = ws_q;
  assign bus.reg_input    = ri_q;
  assign bus.last_grant   = last;
  assign bus.hazard0      = we_q && (ws_q == bus.read_port0_select);
  assign bus.hazard1      = we_q && (ws_q == bus.read_port1_select);
  assign dbg_state        = state;

endmodule
